// File: rtl/adc_serial_reg_slave_pkg.sv
// Shared word layout and state encoding for the ADC serial register slave.
package adc_serial_reg_slave_pkg;

  localparam int DATA_LSB  = 0;
  localparam int DATA_MSB  = 15;
  localparam int ADDR_LSB  = 16;
  localparam int ADDR_MSB  = 19;
  localparam int HDR_LSB   = 20;
  localparam int HDR_MSB   = 31;
  localparam int WORD_BITS = 32;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
  localparam logic [1:0] ST_COMMIT_ENC = 2'd2;
  localparam logic [1:0] ST_ERROR_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SHIFT  = ST_SHIFT_ENC,
    ST_COMMIT = ST_COMMIT_ENC,
    ST_ERROR  = ST_ERROR_ENC
  } state_e;

endpackage

// File: rtl/adc_serial_reg_slave_if.sv
// 3-wire ADC configuration link: serial clock, serial data, active-low select.
interface adc_serial_reg_slave_if;
  logic sclk;
  logic sdata;
  logic select;

  modport master (output sclk, output sdata, output select);
  modport slave  (input  sclk, input  sdata, input  select);
endinterface

// File: rtl/adc_serial_reg_slave_sync_edge_detect.sv
// Multi-flop synchronizer with rising-edge detect on the synchronized level.
// Flops reset to 1 so an idle-high line produces no spurious rise after reset.
module adc_serial_reg_slave_sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign q_o    = sync_q[N-1];
  assign rise_o = sync_q[N-1] & ~prev_q;

endmodule

// File: rtl/adc_serial_reg_slave.sv
// Deserializes LSB-first 32-bit config words from the 3-wire link and commits
// header-matching words into a 16 x 16-bit shadow register file.
module adc_serial_reg_slave
  import adc_serial_reg_slave_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] HEADER      = 12'h000,
  parameter logic [3:0]  DES_ADDR    = 4'd8
) (
  input  logic                   clk,
  input  logic                   rst,
  adc_serial_reg_slave_if.slave  link,
  input  logic [3:0]             rd_addr_i,
  output logic [15:0]            rd_data_o,
  output logic                   wr_strobe_o,
  output logic [3:0]             wr_addr_o,
  output logic [15:0]            wr_data_o,
  output logic                   frame_err_o,
  output logic                   des_active_o,
  output logic [7:0]             word_count_o
);

  logic s_sclk, s_sdata, s_sel, sclk_rise;
  logic unused_sdata_rise, unused_sel_rise, unused_s_sclk;

  adc_serial_reg_slave_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(link.sclk), .q_o(s_sclk), .rise_o(sclk_rise)
  );
  adc_serial_reg_slave_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst(rst), .d_i(link.sdata), .q_o(s_sdata), .rise_o(unused_sdata_rise)
  );
  adc_serial_reg_slave_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .rst(rst), .d_i(link.select), .q_o(s_sel), .rise_o(unused_sel_rise)
  );
  assign unused_s_sclk = s_sclk;

  state_e                 state_q;
  logic [WORD_BITS-1:0]   shift_reg_q;
  logic [4:0]             bitcnt_q;
  logic [15:0]            regs_q [16];
  logic                   wr_strobe_q, frame_err_q;
  logic [3:0]             wr_addr_q;
  logic [15:0]            wr_data_q;
  logic [7:0]             word_count_q;

  logic [3:0]  word_addr;
  logic [15:0] word_data;
  logic [11:0] word_hdr;
  assign word_addr = shift_reg_q[ADDR_MSB:ADDR_LSB];
  assign word_data = shift_reg_q[DATA_MSB:DATA_LSB];
  assign word_hdr  = shift_reg_q[HDR_MSB:HDR_LSB];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_reg_q  <= '0;
      bitcnt_q     <= '0;
      wr_strobe_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          bitcnt_q <= '0;
          if (!s_sel) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // A bit-31 rise wins over a simultaneous select release: word is complete.
          if (sclk_rise && bitcnt_q == 5'd31) begin
            shift_reg_q[31] <= s_sdata;
            bitcnt_q        <= '0;
            state_q         <= ST_COMMIT;
          end else if (s_sel) begin
            state_q <= (bitcnt_q != 5'd0) ? ST_ERROR : ST_IDLE;
          end else if (sclk_rise) begin
            shift_reg_q[bitcnt_q] <= s_sdata;
            bitcnt_q              <= bitcnt_q + 5'd1;
          end
        end
        ST_COMMIT: begin
          if (word_hdr == HEADER) begin
            regs_q[word_addr] <= word_data;
            wr_strobe_q       <= 1'b1;
            wr_addr_q         <= word_addr;
            wr_data_q         <= word_data;
            if (word_count_q != 8'hFF) word_count_q <= word_count_q + 8'd1;
          end else begin
            frame_err_q <= 1'b1;
          end
          bitcnt_q <= '0;
          if (s_sel) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_SHIFT;
            // Next word's bit 0 may arrive while we are committing.
            if (sclk_rise) begin
              shift_reg_q[0] <= s_sdata;
              bitcnt_q       <= 5'd1;
            end
          end
        end
        ST_ERROR: begin
          frame_err_q <= 1'b1;
          bitcnt_q    <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_data_o    = regs_q[rd_addr_i];
  assign wr_strobe_o  = wr_strobe_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign frame_err_o  = frame_err_q;
  assign des_active_o = regs_q[DES_ADDR][0];
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_adc_serial_reg_slave.sv
// Scoreboard bench: expected commits are queued as words are sent, popped on wr_strobe.
module tb_adc_serial_reg_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        wr_strobe, frame_err, des_active;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  word_count;

  adc_serial_reg_slave_if link();

  adc_serial_reg_slave dut (
    .clk(clk), .rst(rst), .link(link),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .frame_err_o(frame_err), .des_active_o(des_active), .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int mcount   = 0;
  logic [19:0] exp_q [$];
  logic [15:0] mregs [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor also runs during reset: any pulse there is unexpected.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (exp_q.size() == 0) begin
          chk("unexp_strobe", 32'd1, 32'd0);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {28'd0, wr_addr}, {28'd0, e[19:16]});
          chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
        end
      end
      if (frame_err) err_seen++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    link.sclk  = 1'b0;
    link.sdata = b;
    wait_clk(8);
    link.sclk = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_word(input logic [31:0] w);
    if (w[31:20] == 12'h000) begin
      exp_q.push_back(w[19:0]);
      mregs[w[19:16]] = w[15:0];
      if (mcount < 255) mcount++;
    end else begin
      err_exp++;
    end
    for (int i = 0; i < 32; i++) send_bit(w[i]);
  endtask

  task automatic frame_start();
    link.select = 1'b0;
    wait_clk(4);
  endtask

  task automatic frame_end();
    link.select = 1'b1;
    wait_clk(12);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      #1;
      chk(tag, {16'd0, rd_data}, {16'd0, mregs[a]});
    end
  endtask

  initial begin
    logic [31:0] w;
    link.sclk = 1'b1; link.sdata = 1'b1; link.select = 1'b1;
    for (int a = 0; a < 16; a++) mregs[a] = '0;
    wait_clk(5);
    chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst_ferr",   {31'd0, frame_err}, 32'd0);
    chk("rst_waddr",  {28'd0, wr_addr}, 32'd0);
    chk("rst_wdata",  {16'd0, wr_data}, 32'd0);
    chk("rst_count",  {24'd0, word_count}, 32'd0);
    rst = 1'b0;
    wait_clk(3);
    check_regs("rst_reg");

    // single word to DES register
    frame_start();
    send_word(32'h0008_0001);
    frame_end();
    chk("des_on",  {31'd0, des_active}, 32'd1);
    chk("count1",  {24'd0, word_count}, mcount);
    chk("waddr1",  {28'd0, wr_addr}, 32'd8);
    chk("wdata1",  {16'd0, wr_data}, 32'h0001);

    // back-to-back burst under one select
    frame_start();
    for (int a = 0; a < 9; a++) begin
      w = {12'h000, a[3:0], 16'h1000 + a[15:0]};
      send_word(w);
    end
    frame_end();
    check_regs("burst_reg");
    chk("burst_ferr", err_seen, err_exp);
    chk("des_off", {31'd0, des_active}, 32'd0);
    chk("count10", {24'd0, word_count}, mcount);

    // bad header
    frame_start();
    send_word(32'h0013_ABCD);
    frame_end();
    chk("hdr_ferr",  err_seen, err_exp);
    chk("hdr_count", {24'd0, word_count}, mcount);
    check_regs("hdr_reg");

    // truncated word, then realignment
    frame_start();
    w = 32'h0000_FFFF;
    for (int i = 0; i < 17; i++) send_bit(w[i]);
    err_exp++;
    link.select = 1'b1;
    wait_clk(20);
    chk("trunc_ferr", err_seen, err_exp);
    frame_start();
    send_word(32'h0002_5555);
    frame_end();
    check_regs("realign_reg");
    chk("realign_ferr", err_seen, err_exp);

    // reset in the middle of a word
    frame_start();
    w = 32'h0004_1234;
    for (int i = 0; i < 20; i++) send_bit(w[i]);
    rst = 1'b1;
    link.select = 1'b1;
    link.sclk   = 1'b1;
    wait_clk(6);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) mregs[a] = '0;
    mcount = 0;
    wait_clk(6);
    chk("rst_mid_count", {24'd0, word_count}, 32'd0);
    frame_start();
    send_word(32'h0004_00FF);
    frame_end();
    check_regs("post_rst_reg");
    chk("post_rst_count", {24'd0, word_count}, mcount);
    chk("post_rst_ferr", err_seen, err_exp);

    // sclk activity while deselected must be ignored
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
    wait_clk(20);
    chk("desel_ferr",  err_seen, err_exp);
    chk("desel_count", {24'd0, word_count}, mcount);
    chk("desel_q",     exp_q.size(), 32'd0);
    check_regs("desel_reg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
